// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the I-cache/D-cache system bus arbiter.
package sys_bus_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned STRB_W     = 4;

  localparam logic M_ICACHE = 1'b0;
  localparam logic M_DCACHE = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WADDR = 3'd3,
    S_WRESP = 3'd4
  } state_e;

endpackage

// File: rtl/sys_arb_pick.sv
// Combinational winner select between the two masters.
// SYS_ARB_RR_EN selects round-robin on ties; otherwise D-cache has fixed priority.
module sys_arb_pick
  import sys_bus_pkg::*;
(
  input  logic [1:0] i_req,
`ifdef SYS_ARB_RR_EN
  input  logic       i_last,
`endif
  output logic [1:0] o_grant_c
);

  always_comb begin
    o_grant_c = 2'b00;
`ifdef SYS_ARB_RR_EN
    // A tie goes to whichever master was not granted last.
    if (&i_req) o_grant_c = (i_last == M_DCACHE) ? 2'b01 : 2'b10;
    else        o_grant_c = i_req;
`else
    if (i_req[M_DCACHE])      o_grant_c = 2'b10;
    else if (i_req[M_ICACHE]) o_grant_c = 2'b01;
`endif
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Two-master (I-cache, D-cache) to one-slave bus arbiter, one transaction in flight.
// Define SYS_ARB_RR_EN for round-robin arbitration; default is fixed D-cache priority.
module sys_bus_arbiter
  import sys_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // master 0: I-cache
  input  logic              m0_readAddr_valid,
  input  logic [ADDR_W-1:0] m0_readAddr_addr,
  input  logic              m0_readData_ready,
  input  logic              m0_writeAddr_valid,
  input  logic [ADDR_W-1:0] m0_writeAddr_addr,
  input  logic              m0_writeData_valid,
  input  logic [DATA_W-1:0] m0_writeData_data,
  input  logic [STRB_W-1:0] m0_writeData_strb,
  input  logic              m0_writeResp_ready,
  output logic              m0_readAddr_ready,
  output logic              m0_readData_valid,
  output logic [DATA_W-1:0] m0_readData_data,
  output logic              m0_writeAddr_ready,
  output logic              m0_writeData_ready,
  output logic              m0_writeResp_valid,
  output logic [DATA_W-1:0] m0_writeResp_msg,
  // master 1: D-cache
  input  logic              m1_readAddr_valid,
  input  logic [ADDR_W-1:0] m1_readAddr_addr,
  input  logic              m1_readData_ready,
  input  logic              m1_writeAddr_valid,
  input  logic [ADDR_W-1:0] m1_writeAddr_addr,
  input  logic              m1_writeData_valid,
  input  logic [DATA_W-1:0] m1_writeData_data,
  input  logic [STRB_W-1:0] m1_writeData_strb,
  input  logic              m1_writeResp_ready,
  output logic              m1_readAddr_ready,
  output logic              m1_readData_valid,
  output logic [DATA_W-1:0] m1_readData_data,
  output logic              m1_writeAddr_ready,
  output logic              m1_writeData_ready,
  output logic              m1_writeResp_valid,
  output logic [DATA_W-1:0] m1_writeResp_msg,
  // slave
  output logic              s_readAddr_valid,
  output logic [ADDR_W-1:0] s_readAddr_addr,
  output logic              s_readData_ready,
  output logic              s_writeAddr_valid,
  output logic [ADDR_W-1:0] s_writeAddr_addr,
  output logic              s_writeData_valid,
  output logic [DATA_W-1:0] s_writeData_data,
  output logic [STRB_W-1:0] s_writeData_strb,
  output logic              s_writeResp_ready,
  input  logic              s_readAddr_ready,
  input  logic              s_readData_valid,
  input  logic [DATA_W-1:0] s_readData_data,
  input  logic              s_writeAddr_ready,
  input  logic              s_writeData_ready,
  input  logic              s_writeResp_valid,
  input  logic [DATA_W-1:0] s_writeResp_msg,
  // status
  output logic [1:0]        grant,
  output logic              busy
);

  state_e            r_state;
  state_e            w_state_nx;
  logic [1:0]        r_grant;
  logic [1:0]        w_grant_nx;
  logic              r_busy;
  logic [1:0]        w_pick;
  logic              w_own;

  logic [1:0]        w_ra_valid, w_rd_ready, w_wa_valid, w_wd_valid, w_resp_ready;
  logic [1:0]        w_wreq, w_req;
  logic [ADDR_W-1:0] w_ra_addr [2];
  logic [ADDR_W-1:0] w_wa_addr [2];
  logic [DATA_W-1:0] w_wd_data [2];
  logic [STRB_W-1:0] w_wd_strb [2];

  logic              w_ra_ready, w_rd_valid, w_wr_ready, w_resp_valid;
  logic [DATA_W-1:0] w_rd_data, w_resp_msg;

  assign w_ra_valid   = {m1_readAddr_valid,  m0_readAddr_valid};
  assign w_rd_ready   = {m1_readData_ready,  m0_readData_ready};
  assign w_wa_valid   = {m1_writeAddr_valid, m0_writeAddr_valid};
  assign w_wd_valid   = {m1_writeData_valid, m0_writeData_valid};
  assign w_resp_ready = {m1_writeResp_ready, m0_writeResp_ready};
  assign w_ra_addr[0] = m0_readAddr_addr;
  assign w_ra_addr[1] = m1_readAddr_addr;
  assign w_wa_addr[0] = m0_writeAddr_addr;
  assign w_wa_addr[1] = m1_writeAddr_addr;
  assign w_wd_data[0] = m0_writeData_data;
  assign w_wd_data[1] = m1_writeData_data;
  assign w_wd_strb[0] = m0_writeData_strb;
  assign w_wd_strb[1] = m1_writeData_strb;

  // A write needs both address and data valid; it outranks a read from the same master.
  assign w_wreq = w_wa_valid & w_wd_valid;
  assign w_req  = w_ra_valid | w_wreq;
  assign w_own  = r_grant[M_DCACHE];

`ifdef SYS_ARB_RR_EN
  logic r_last;

  always_ff @(posedge clk) begin
    if (rst)                            r_last <= M_DCACHE;
    else if (r_state == S_IDLE && |w_pick) r_last <= w_pick[M_DCACHE];
  end

  sys_arb_pick u_pick (.i_req(w_req), .i_last(r_last), .o_grant_c(w_pick));
`else
  sys_arb_pick u_pick (.i_req(w_req), .o_grant_c(w_pick));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= 2'b00;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_busy  <= (w_state_nx != S_IDLE);
    end
  end

  // Next state plus owner<->slave routing for the current phase.
  always_comb begin
    w_state_nx        = r_state;
    w_grant_nx        = r_grant;
    w_ra_ready        = 1'b0;
    w_rd_valid        = 1'b0;
    w_rd_data         = '0;
    w_wr_ready        = 1'b0;
    w_resp_valid      = 1'b0;
    w_resp_msg        = '0;
    s_readAddr_valid  = 1'b0;
    s_readAddr_addr   = '0;
    s_readData_ready  = 1'b0;
    s_writeAddr_valid = 1'b0;
    s_writeAddr_addr  = '0;
    s_writeData_valid = 1'b0;
    s_writeData_data  = '0;
    s_writeData_strb  = '0;
    s_writeResp_ready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|w_pick) begin
          w_grant_nx = w_pick;
          w_state_nx = w_wreq[w_pick[M_DCACHE]] ? S_WADDR : S_RADDR;
        end
      end
      S_RADDR: begin
        s_readAddr_valid = w_ra_valid[w_own];
        s_readAddr_addr  = w_ra_addr[w_own];
        w_ra_ready       = s_readAddr_ready;
        if (w_ra_valid[w_own] && s_readAddr_ready) w_state_nx = S_RDATA;
      end
      S_RDATA: begin
        w_rd_valid       = s_readData_valid;
        w_rd_data        = s_readData_data;
        s_readData_ready = w_rd_ready[w_own];
        if (s_readData_valid && w_rd_ready[w_own]) begin
          w_state_nx = S_IDLE;
          w_grant_nx = 2'b00;
        end
      end
      S_WADDR: begin
        s_writeAddr_valid = w_wa_valid[w_own];
        s_writeAddr_addr  = w_wa_addr[w_own];
        s_writeData_valid = w_wd_valid[w_own];
        s_writeData_data  = w_wd_data[w_own];
        s_writeData_strb  = w_wd_strb[w_own];
        w_wr_ready        = s_writeAddr_ready & s_writeData_ready;
        if (w_wreq[w_own] && w_wr_ready) w_state_nx = S_WRESP;
      end
      S_WRESP: begin
        w_resp_valid      = s_writeResp_valid;
        w_resp_msg        = s_writeResp_msg;
        s_writeResp_ready = w_resp_ready[w_own];
        if (s_writeResp_valid && w_resp_ready[w_own]) begin
          w_state_nx = S_IDLE;
          w_grant_nx = 2'b00;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_grant_nx = 2'b00;
      end
    endcase
  end

  // Only the owner sees slave responses; everyone else reads zeros.
  assign m0_readAddr_ready  = r_grant[M_ICACHE] & w_ra_ready;
  assign m0_readData_valid  = r_grant[M_ICACHE] & w_rd_valid;
  assign m0_readData_data   = r_grant[M_ICACHE] ? w_rd_data : '0;
  assign m0_writeAddr_ready = r_grant[M_ICACHE] & w_wr_ready;
  assign m0_writeData_ready = r_grant[M_ICACHE] & w_wr_ready;
  assign m0_writeResp_valid = r_grant[M_ICACHE] & w_resp_valid;
  assign m0_writeResp_msg   = r_grant[M_ICACHE] ? w_resp_msg : '0;

  assign m1_readAddr_ready  = r_grant[M_DCACHE] & w_ra_ready;
  assign m1_readData_valid  = r_grant[M_DCACHE] & w_rd_valid;
  assign m1_readData_data   = r_grant[M_DCACHE] ? w_rd_data : '0;
  assign m1_writeAddr_ready = r_grant[M_DCACHE] & w_wr_ready;
  assign m1_writeData_ready = r_grant[M_DCACHE] & w_wr_ready;
  assign m1_writeResp_valid = r_grant[M_DCACHE] & w_resp_valid;
  assign m1_writeResp_msg   = r_grant[M_DCACHE] ? w_resp_msg : '0;

  assign grant = r_grant;
  assign busy  = r_busy;

endmodule
